// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS waveform generator.
package dds_pkg;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SAW      = 2'd3
    } wave_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned PIPE_LAT = 3;

endpackage

// File: rtl/dds_wave_gen_if.sv
// Configuration handshake and DAC data bus of the DDS generator.
interface dds_wave_gen_if #(
    parameter int unsigned DW   = 8,
    parameter int unsigned PW   = 24,
    parameter int unsigned AMPW = 8
);
    logic            en;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_wave;
    logic [PW-1:0]   cfg_ftw;
    logic [PW-1:0]   cfg_phase;
    logic [PW-1:0]   cfg_duty;
    logic [AMPW-1:0] cfg_amp;
    logic [DW-1:0]   data_out;
    logic            data_valid;
    logic            sync;
    logic            da_clk;

    modport master (
        output en, cfg_valid, cfg_wave, cfg_ftw, cfg_phase, cfg_duty, cfg_amp,
        input  cfg_ready, data_out, data_valid, sync, da_clk
    );

    modport slave (
        input  en, cfg_valid, cfg_wave, cfg_ftw, cfg_phase, cfg_duty, cfg_amp,
        output cfg_ready, data_out, data_valid, sync, da_clk
    );
endinterface

// File: rtl/sine_qrom.sv
// Quarter-wave sine ROM, contents computed at elaboration, one-cycle registered read.
module sine_qrom #(
    parameter int unsigned DW     = 8,
    parameter int unsigned LUT_AW = 8
) (
    input  logic              clk,
    input  logic [LUT_AW-1:0] addr,
    output logic [DW-2:0]     q
);
    localparam int unsigned DEPTH = 2 ** LUT_AW;
    localparam real         PI    = 3.14159265358979323846;
    localparam real         AMP   = real'(2 ** (DW - 1) - 1);

    logic [DW-2:0] rom [DEPTH];

    // Sample at bin centres so the table never hits exactly 0 or the peak twice.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real ANG = PI / 2.0 * (real'(i) + 0.5) / real'(DEPTH);
        localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
        assign rom[i] = VAL[DW-2:0];
    end

    always_ff @(posedge clk) begin
        q <= rom[addr];
    end
endmodule

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS: sine/square/triangle/saw with shadowed config applied at wrap.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned PW     = 24,
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned AMPW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dds_wave_gen_if.slave bus
);
    localparam int unsigned   MW       = DW + AMPW + 1;
    localparam logic [PW-1:0] DUTY_RST = {1'b1, {(PW-1){1'b0}}};
    localparam logic [DW-1:0] MID      = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MID_M1   = {1'b0, {(DW-1){1'b1}}};

    state_e state_q, state_d;
    logic   run;

    logic [PW-1:0]   acc_q;
    logic [PW:0]     acc_sum;
    logic            wrap, xfer, commit, pending_q, sync_q;

    wave_e           wave_q, sh_wave_q;
    logic [PW-1:0]   ftw_q, phase_q, duty_q, sh_ftw_q, sh_phase_q, sh_duty_q;
    logic [AMPW-1:0] amp_q, sh_amp_q;

    logic [PW-1:0]     ph_q;
    logic [DW:0]       tri_t;
    logic [DW-1:0]     raw_d, raw_q, sine_raw, sel_raw, out_q;
    logic [LUT_AW-1:0] rom_a, rom_addr;
    logic [DW-2:0]     rom_q;
    wave_e             wave1_q;
    logic              sign_q;
    logic [AMPW:0]     amp_p1;
    logic [MW-1:0]     prod;
    logic [PIPE_LAT-1:0] valid_q;

    // State machine
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.en)  state_d = RUN;
            RUN:  if (!bus.en) state_d = IDLE;
        endcase
    end

    always_comb begin
        run = (state_q == RUN);
    end

    // Accumulator and config handshake
    assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};
    assign wrap    = run & bus.en & acc_sum[PW];
    assign xfer    = bus.cfg_valid & ~pending_q;
    // Idle commits right away; running commits only at a wrap so a period is never torn.
    assign commit  = pending_q & (run ? wrap : 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q      <= '0;
            sync_q     <= 1'b0;
            pending_q  <= 1'b0;
            wave_q     <= SINE;
            ftw_q      <= '0;
            phase_q    <= '0;
            duty_q     <= DUTY_RST;
            amp_q      <= '1;
            sh_wave_q  <= SINE;
            sh_ftw_q   <= '0;
            sh_phase_q <= '0;
            sh_duty_q  <= DUTY_RST;
            sh_amp_q   <= '1;
        end else begin
            acc_q  <= (run && bus.en) ? acc_sum[PW-1:0] : '0;
            sync_q <= wrap;
            if (xfer) begin
                pending_q  <= 1'b1;
                sh_wave_q  <= wave_e'(bus.cfg_wave);
                sh_ftw_q   <= bus.cfg_ftw;
                sh_phase_q <= bus.cfg_phase;
                sh_duty_q  <= bus.cfg_duty;
                sh_amp_q   <= bus.cfg_amp;
            end else if (commit) begin
                pending_q <= 1'b0;
                wave_q    <= sh_wave_q;
                ftw_q     <= sh_ftw_q;
                phase_q   <= sh_phase_q;
                duty_q    <= sh_duty_q;
                amp_q     <= sh_amp_q;
            end
        end
    end

    // S1: waveform shaping; sine goes through the synchronous ROM
    assign tri_t    = ph_q[PW-1 -: DW+1];
    assign rom_a    = ph_q[PW-3 -: LUT_AW];
    assign rom_addr = ph_q[PW-2] ? ~rom_a : rom_a;

    always_comb begin
        raw_d = ph_q[PW-1 -: DW];
        unique case (wave_q)
            SQUARE:   raw_d = (ph_q < duty_q) ? '0 : '1;
            TRIANGLE: raw_d = tri_t[DW] ? ~tri_t[DW-1:0] : tri_t[DW-1:0];
            default:  raw_d = ph_q[PW-1 -: DW];
        endcase
    end

    sine_qrom #(
        .DW     (DW),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .q    (rom_q)
    );

    // S2: amplitude scaling
    assign sine_raw = sign_q ? (MID_M1 - {1'b0, rom_q}) : (MID + {1'b0, rom_q});
    assign sel_raw  = (wave1_q == SINE) ? sine_raw : raw_q;
    assign amp_p1   = {1'b0, amp_q} + {{AMPW{1'b0}}, 1'b1};
    assign prod     = MW'(sel_raw) * MW'(amp_p1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q    <= '0;
            raw_q   <= '0;
            wave1_q <= SINE;
            sign_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= '0;
        end else begin
            ph_q    <= acc_q + phase_q;
            raw_q   <= raw_d;
            wave1_q <= wave_q;
            sign_q  <= ph_q[PW-1];
            out_q   <= valid_q[1] ? DW'(prod >> AMPW) : '0;
            valid_q <= {valid_q[PIPE_LAT-2:0], run};
        end
    end

    assign bus.cfg_ready  = ~pending_q;
    assign bus.data_out   = out_q;
    assign bus.data_valid = valid_q[PIPE_LAT-1];
    assign bus.sync       = sync_q;
    assign bus.da_clk     = clk;
endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: expected samples queued per scenario, popped on data_valid.
module tb_dds_wave_gen;
    import dds_pkg::*;

    localparam logic [23:0] DUTY = 24'h800000;
    localparam logic [23:0] F16  = 24'h010000;
    localparam logic [23:0] F17  = 24'h020000;
    localparam logic [23:0] F18  = 24'h040000;
    localparam logic [23:0] F20  = 24'h100000;
    localparam real         PI   = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   sb_en = 1'b0;
    logic [7:0] exp_q[$];
    int   smin, smax;

    dds_wave_gen_if #(.DW(8), .PW(24), .AMPW(8)) bus ();

    dds_wave_gen #(.DW(8), .PW(24), .LUT_AW(8), .AMPW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, pop the scoreboard on a live sample.
    task automatic cyc();
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (sb_en && bus.data_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(bus.data_out), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sample", 32'(bus.data_out), 32'(e));
                if (int'(bus.data_out) < smin) smin = int'(bus.data_out);
                if (int'(bus.data_out) > smax) smax = int'(bus.data_out);
            end
        end
    endtask

    task automatic cfg_load(input logic [1:0] w, input logic [23:0] f, input logic [23:0] p,
                            input logic [23:0] d, input logic [7:0] a);
        bus.cfg_wave  = w;
        bus.cfg_ftw   = f;
        bus.cfg_phase = p;
        bus.cfg_duty  = d;
        bus.cfg_amp   = a;
        bus.cfg_valid = 1'b1;
        cyc();
        check("ready_drop", 32'(bus.cfg_ready), 0);
        bus.cfg_valid = 1'b0;
        cyc();
        check("ready_rise", 32'(bus.cfg_ready), 1);
    endtask

    task automatic run_n(input int n);
        bus.en = 1'b1;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic stop_run();
        bus.en = 1'b0;
        repeat (3) cyc();
        check("dv_hold", 32'(bus.data_valid), 1);
        cyc();
        check("dv_fall", 32'(bus.data_valid), 0);
        check("dout_idle", 32'(bus.data_out), 0);
        check("sb_drain", 32'(exp_q.size()), 0);
        sb_en = 1'b0;
    endtask

    function automatic logic [7:0] sine_model(input logic [23:0] ph);
        int  a, idx, q;
        real ang;
        a   = int'(ph[21:14]);
        idx = ph[22] ? 255 - a : a;
        ang = PI / 2.0 * (real'(idx) + 0.5) / 256.0;
        q   = $rtoi(127.0 * $sin(ang) + 0.5);
        return 8'(ph[23] ? 127 - q : 128 + q);
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_wave = 2'd0;
        bus.cfg_ftw = '0;
        bus.cfg_phase = '0;
        bus.cfg_duty = '0;
        bus.cfg_amp = '0;
        repeat (2) cyc();
        check("rst_dout", 32'(bus.data_out), 0);
        check("rst_dv", 32'(bus.data_valid), 0);
        check("rst_sync", 32'(bus.sync), 0);
        check("rst_ready", 32'(bus.cfg_ready), 1);
        check("da_clk", 32'(bus.da_clk), 32'(clk));
        rst_n = 1'b1;
        cyc();

        // Saw, two full periods, latency and sync spacing
        cfg_load(SAW, F16, 24'h0, DUTY, 8'd255);
        for (int k = 0; k < 520; k++) exp_q.push_back(8'(k % 256));
        sb_en = 1'b1;
        bus.en = 1'b1;
        for (int n = 1; n <= 520; n++) begin
            cyc();
            check("saw_sync", 32'(bus.sync), 32'((n > 1) && ((n - 1) % 256 == 0)));
            if (n == 3) check("dv_lat_lo", 32'(bus.data_valid), 0);
            if (n == 4) check("dv_lat_hi", 32'(bus.data_valid), 1);
        end
        stop_run();

        // Restart from a phase offset of half a turn
        cfg_load(SAW, F16, 24'h800000, DUTY, 8'd255);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'((128 + k) % 256));
        sb_en = 1'b1;
        run_n(16);
        stop_run();

        // Square, full and half amplitude
        cfg_load(SQUARE, F20, 24'h0, DUTY, 8'd255);
        for (int k = 0; k < 40; k++) exp_q.push_back((k % 16) < 8 ? 8'd0 : 8'd255);
        sb_en = 1'b1;
        run_n(40);
        stop_run();
        cfg_load(SQUARE, F20, 24'h0, DUTY, 8'd127);
        for (int k = 0; k < 40; k++) exp_q.push_back((k % 16) < 8 ? 8'd0 : 8'd127);
        sb_en = 1'b1;
        run_n(40);
        stop_run();

        // Triangle
        cfg_load(TRIANGLE, F16, 24'h0, DUTY, 8'd255);
        for (int k = 0; k < 300; k++) begin
            int j;
            j = k % 256;
            exp_q.push_back(8'(j < 128 ? 2 * j : 255 - 2 * (j - 128)));
        end
        sb_en = 1'b1;
        run_n(300);
        stop_run();

        // Sine
        cfg_load(SINE, F16, 24'h0, DUTY, 8'd255);
        for (int k = 0; k < 260; k++) exp_q.push_back(sine_model(24'(k * 65536)));
        smin = 255;
        smax = 0;
        sb_en = 1'b1;
        run_n(260);
        stop_run();
        check("sine_peak", 32'(smax >= 254), 1);
        check("sine_trough", 32'(smin <= 1), 1);

        // Mid-period ftw change; a second offer while pending must be ignored
        cfg_load(SAW, F16, 24'h0, DUTY, 8'd255);
        for (int k = 0; k < 300; k++)
            exp_q.push_back(8'(k < 256 ? k : (2 * (k - 256)) % 256));
        sb_en = 1'b1;
        bus.en = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            cyc();
            check("upd_sync", 32'(bus.sync), 32'(n == 257));
            if (n == 100) begin
                bus.cfg_ftw = F17;
                bus.cfg_valid = 1'b1;
            end
            if (n == 101) begin
                check("upd_ready_drop", 32'(bus.cfg_ready), 0);
                bus.cfg_ftw = F18;
            end
            if (n == 102) begin
                check("upd_ready_busy", 32'(bus.cfg_ready), 0);
                bus.cfg_valid = 1'b0;
            end
            if (n == 256) check("upd_ready_wait", 32'(bus.cfg_ready), 0);
            if (n == 257) check("upd_ready_rise", 32'(bus.cfg_ready), 1);
        end
        stop_run();

        // Reset mid-run with a pending config
        cfg_load(SAW, F16, 24'h0, DUTY, 8'd255);
        bus.en = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            cyc();
            if (n == 50) begin
                bus.cfg_wave = SQUARE;
                bus.cfg_ftw = F20;
                bus.cfg_amp = 8'd7;
                bus.cfg_valid = 1'b1;
            end
            if (n == 51) begin
                bus.cfg_valid = 1'b0;
                check("pend_ready", 32'(bus.cfg_ready), 0);
            end
        end
        rst_n = 1'b0;
        bus.en = 1'b0;
        cyc();
        check("mrst_dout", 32'(bus.data_out), 0);
        check("mrst_dv", 32'(bus.data_valid), 0);
        check("mrst_sync", 32'(bus.sync), 0);
        check("mrst_ready", 32'(bus.cfg_ready), 1);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            check("mrst_no_pend", 32'(bus.cfg_ready), 1);
        end
        // Defaults: sine, ftw=0, phase=0, full amplitude -> constant mid-scale
        for (int k = 0; k < 12; k++) exp_q.push_back(8'd128);
        sb_en = 1'b1;
        bus.en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cyc();
            check("dflt_nosync", 32'(bus.sync), 0);
        end
        stop_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
